// File: rtl/seq_divider_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider_param: iterative restoring divider, signed/unsigned, div0.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_divider_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_r;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic             w_unused;

  assign w_dvd_neg = in_signed & in_dividend[WIDTH-1];
  assign w_dvs_neg = in_signed & in_divisor[WIDTH-1];
  // Negating the most-negative value yields 2^(WIDTH-1), the correct magnitude.
  assign w_dvd_mag = w_dvd_neg ? (~in_dividend + 1'b1) : in_dividend;
  assign w_dvs_mag = w_dvs_neg ? (~in_divisor + 1'b1) : in_divisor;

  assign w_shift   = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_q_fin   = r_q_neg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_r_fin   = r_r_neg ? (~w_rem_nxt[WIDTH-1:0] + 1'b1) : w_rem_nxt[WIDTH-1:0];

  // The partial remainder never exceeds the divisor, so its top bit is never consumed.
  assign w_unused = r_rem[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_r     <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            if (in_divisor == '0) begin
              r_out_q     <= '1;
              r_out_r     <= in_dividend;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out_q     <= w_q_fin;
            r_out_r     <= w_r_fin;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign out_valid       = r_out_valid;
  assign out_quotient    = r_out_q;
  assign out_remainder   = r_out_r;
  assign out_div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised iterative restoring divider; successor to the fixed 16-bit serial divider.
- Adds generic WIDTH, per-operation signed/unsigned mode, divide-by-zero detection, and valid/ready handshakes on input and output with output backpressure.
- Sits as a multi-cycle arithmetic unit beside the datapath; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  divider can accept; high only in IDLE.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- in_dividend  input  WIDTH  dividend.
- in_divisor  input  WIDTH  divisor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_quotient  output  WIDTH  quotient.
- out_remainder  output  WIDTH  remainder.
- out_div_by_zero  output  1  divisor was zero for this result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, out_quotient=0, out_remainder=0, out_div_by_zero=0, busy=0; in_ready=1 after release; internal regs cleared.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept when in_valid&&in_ready at a rising edge. On accept, latch mode, operand magnitudes (abs if signed and negative), result sign flags; clear partial remainder; counter=0.
  - divisor==0: go to DONE directly (latency 1).
  - Otherwise go to CALC.
- CALC: one quotient bit per cycle, MSB first. Shift the partial remainder (WIDTH+1 bits) left with the next dividend bit. If the result is >= divisor magnitude, subtract it and set the quotient bit to 1; otherwise set it to 0. Counter increments each cycle.
- CALC completion: on the WIDTH-th iteration edge, apply sign correction and register outputs in the same edge, then go to DONE.
  - out_valid rises exactly WIDTH cycles after the accept edge.
- Sign rules (signed mode): truncation toward zero.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitude of most-negative value = 2^(WIDTH-1) as an unsigned WIDTH-bit value.
- Overflow case (signed, most-negative / -1): quotient = most-negative value, remainder = 0. No flag. This falls out of the rules above.
- Divide by zero (both modes): out_quotient = all ones, out_remainder = dividend unmodified, out_div_by_zero=1.
- Unsigned mode: no sign processing; identical to plain restoring division.
- DONE: out_valid=1. Outputs held stable until out_valid&&out_ready; then out_valid=0 and state IDLE on that edge.
  - in_ready stays 0 throughout DONE.
  - No new operation is accepted in the same cycle as the output handshake; the next accept is possible one cycle later.
- out_ready is ignored outside DONE. in_valid is ignored while in_ready=0, and operand changes then have no effect.
- out_div_by_zero is updated on every completion; it is not sticky.
- busy = (state != IDLE).

Test Plan:
- Unsigned 100/7 (WIDTH=16), out_ready=1 -> out_valid exactly 16 cycles after accept; q=14, r=2, dbz=0; IDLE and in_ready=1 the next cycle.
- Signed -100/7 and 100/-7 -> q=0xFFF2, r=0xFFFE; then q=0xFFF2, r=0x0002. Unsigned 0xFFFF/0x0001 -> q=0xFFFF, r=0.
- Signed 0x8000/0xFFFF -> q=0x8000, r=0x0000, dbz=0. Unsigned 0x8000/0xFFFF -> q=0, r=0x8000.
- 1234/0, either mode -> out_valid 1 cycle after accept; q=0xFFFF, r=0x04D2, dbz=1. Following 10/3 -> q=3, r=1, dbz=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> handshake; new op accepted the next cycle.
- Assert rst_n=0 mid-CALC (cycle 7) -> all outputs 0 immediately. After release: IDLE, in_ready=1; next op 50/5 -> q=10, r=0. Repeat with WIDTH=8 and WIDTH=32 at random operands against a reference model.
